load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator on the word-granular cache bus: converts datapath load/store requests into word-aligned cache transactions.
- Sits between the datapath memory stage and the data cache.
- Handles byte/halfword/word sizes, load sign/zero extension and misalignment detection.
- Sub-word stores are done as read-modify-write, because the cache bus writes whole words only.

Parameters:
ADDR_SIZE, 32, address width in bits
WORD_SIZE, 32, cache word / data width in bits (fixed at 32 for this block)

Ports:
clk_i  input  1  clock
reset_ni  input  1  reset, asynchronous, active-low
req_valid_i  input  1  datapath request strobe
req_ready_o  output  1  unit can accept request
req_store_i  input  1  1 = store, 0 = load
req_size_i  input  2  00 byte, 01 half, 10 word, 11 invalid
req_unsigned_i  input  1  load zero-extends when 1
req_addr_i  input  ADDR_SIZE  byte address
req_data_i  input  WORD_SIZE  store data, right-aligned
resp_valid_o  output  1  one-cycle completion pulse
resp_data_o  output  WORD_SIZE  load result (0 for stores/errors)
resp_error_o  output  1  misaligned or invalid size
cache_valid_o  output  1  cache request valid
cache_write_o  output  1  cache request is write
cache_addr_o  output  ADDR_SIZE  word address, low 2 bits zero
cache_data_o  output  WORD_SIZE  cache write data
cache_ready_i  input  1  cache accepts/completes request
cache_data_i  input  WORD_SIZE  cache read data, valid when cache_ready_i

Behaviour:
- Clock and reset (already decided): one clock, clk_i; reset_ni is asynchronous and active-low.
- Reset values: state IDLE; req_ready_o=1; resp_valid_o=0; resp_data_o=0; resp_error_o=0; cache_valid_o=0; cache_write_o=0; cache_addr_o=0; cache_data_o=0.
- Request handshake: a request is accepted on req_valid_i && req_ready_o. req_ready_o=1 only in IDLE. The accepted request is latched into internal registers; inputs are don't-care afterwards.
- Cache handshake:
  - cache_valid_o, cache_write_o, cache_addr_o and cache_data_o are registered and held stable until the cycle where cache_valid_o && cache_ready_i. That cycle completes the transaction.
  - Read data is sampled in that same cycle.
  - cache_valid_o is deasserted the following cycle unless a new phase starts.
- Error check at accept:
  - half with addr[0]=1, word with addr[1:0]!=0, or size=11 → error.
  - Error path: go to RESP with resp_error_o=1 and resp_data_o=0. No cache access.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE → RESP on error.
  - IDLE → WRITE on word store (cache_data_o = req_data).
  - IDLE → READ on any load or sub-word store.
  - READ, on handshake: load → RESP with extracted data; sub-word store → WRITE with merged word.
  - WRITE, on handshake → RESP.
  - RESP → IDLE unconditionally. resp_valid_o=1 for exactly this one cycle; there is no response backpressure.
- Latency: request accepted at cycle T. First cache_valid_o at T+1. Cache handshake at cycle R. resp_valid_o at R+1.
  - Sub-word store: write phase starts at R1+1; response one cycle after the write handshake.
  - Error: resp_valid_o at T+1.
- Load extraction:
  - lane = addr[1:0].
  - byte = word[8*lane +: 8]; half = word[16*addr[1] +: 16].
  - Sign-extend from bit 7/15 unless req_unsigned_i.
- Store merge: replace only the addressed byte or half lane of the read word with the low bits of req_data; other lanes are unchanged.
- Cache address: {addr[ADDR_SIZE-1:2], 2'b00}, for both phases of read-modify-write.
- Stalls: cache_ready_i low for any number of cycles → outputs hold, no timeout.
- Reset mid-transaction: all state and outputs return to reset values asynchronously. The in-flight request is dropped. The system resets the cache together with this unit.
- req_valid_i while busy: ignored (req_ready_o=0). The requester must hold it.

Decomposition:
- Package definitions gets:
  - mem_size_t enum (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10);
  - lsu_state_t enum (IDLE, READ, WRITE, RESP).
- One combinational sub-module, lsu_align: inputs word, addr[1:0], size, unsigned, store data; outputs extracted load value, merged store word, misaligned flag.

Test Plan:
- Reset mid-READ (pull reset_ni low asynchronously while cache_valid_o=1) → all outputs 0 immediately, req_ready_o=1; after release a word load at 0x0 completes normally.
- Word load at 0x100, cache returns 0xDEADBEEF with ready 3 cycles after valid → resp_valid_o once, 4 cycles after first cache_valid_o, resp_data_o=0xDEADBEEF, error=0.
- Byte load 0x103 signed, cache word 0x80FF_1234 → resp_data_o=0xFFFFFF80; same load unsigned → 0x00000080; half load 0x102 signed → 0xFFFF80FF.
- Byte store 0x201, data 0xAB, cache read word 0x11223344 → second transaction is a write to 0x200 with data 0x1122AB44, then resp_valid_o with error=0.
- Word load at 0x102 and half store at 0x301 → resp_valid_o at T+1, resp_error_o=1, cache_valid_o never asserted.
- Word store 0x400 data 0xCAFEBABE with cache_ready_i tied high → single write beat at T+1, resp at T+2, req_ready_o back to 1 at T+3; a back-to-back request is accepted then.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes and controller states.
package lsu_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: load extraction with sign/zero
// extension, sub-word store merge into a full word, and alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word_i[{lane_i, 3'b000} +: 8];
  assign half_v = word_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o  = word_i;
    merged_o     = word_i;
    misaligned_o = 1'b0;
    case (size_i)
      MEM_BYTE: begin
        load_data_o = {{24{~unsigned_i & byte_v[7]}}, byte_v};
        merged_o[{lane_i, 3'b000} +: 8] = store_data_i[7:0];
      end
      MEM_HALF: begin
        load_data_o = {{16{~unsigned_i & half_v[15]}}, half_v};
        merged_o[{lane_i[1], 4'b0000} +: 16] = store_data_i[15:0];
        misaligned_o = lane_i[0];
      end
      MEM_WORD: begin
        merged_o     = store_data_i;
        misaligned_o = |lane_i;
      end
      default: begin
        // size 2'b11 is not a legal access; treat it like a misalignment
        load_data_o  = '0;
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns datapath byte/half/word requests into word-aligned
// cache transactions, using read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_store_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [ADDR_SIZE-1:0] req_addr_i,
  input  logic [WORD_SIZE-1:0] req_data_i,
  output logic                 resp_valid_o,
  output logic [WORD_SIZE-1:0] resp_data_o,
  output logic                 resp_error_o,
  output logic                 cache_valid_o,
  output logic                 cache_write_o,
  output logic [ADDR_SIZE-1:0] cache_addr_o,
  output logic [WORD_SIZE-1:0] cache_data_o,
  input  logic                 cache_ready_i,
  input  logic [WORD_SIZE-1:0] cache_data_i
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. req_ready_o is high only in IDLE; cache_* outputs stay stable
  // from assertion of cache_valid_o until the edge where cache_ready_i is high.

  lsu_state_t           state_q;
  logic                 store_q, unsigned_q;
  logic [1:0]           size_q, lane_q;
  logic [WORD_SIZE-1:0] data_q;
  logic                 resp_valid_q, resp_error_q;
  logic [WORD_SIZE-1:0] resp_data_q, cache_data_q;
  logic                 cache_valid_q, cache_write_q;
  logic [ADDR_SIZE-1:0] cache_addr_q;

  logic [1:0]           al_lane, al_size;
  logic [WORD_SIZE-1:0] al_load, al_merged;
  logic                 al_misaligned;

  // In IDLE the aligner checks the incoming request; afterwards it works on
  // the latched request against the word returned by the cache.
  assign al_lane = (state_q == IDLE) ? req_addr_i[1:0] : lane_q;
  assign al_size = (state_q == IDLE) ? req_size_i : size_q;

  lsu_align u_align (
    .word_i       (cache_data_i),
    .lane_i       (al_lane),
    .size_i       (al_size),
    .unsigned_i   (unsigned_q),
    .store_data_i (data_q),
    .load_data_o  (al_load),
    .merged_o     (al_merged),
    .misaligned_o (al_misaligned)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= IDLE;
      store_q       <= 1'b0;
      unsigned_q    <= 1'b0;
      size_q        <= 2'b00;
      lane_q        <= 2'b00;
      data_q        <= '0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_data_q   <= '0;
      cache_valid_q <= 1'b0;
      cache_write_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            store_q      <= req_store_i;
            unsigned_q   <= req_unsigned_i;
            size_q       <= req_size_i;
            lane_q       <= req_addr_i[1:0];
            data_q       <= req_data_i;
            resp_data_q  <= '0;
            resp_error_q <= al_misaligned;
            if (al_misaligned) begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              cache_valid_q <= 1'b1;
              cache_addr_q  <= {req_addr_i[ADDR_SIZE-1:2], 2'b00};
              if (req_store_i && req_size_i == MEM_WORD) begin
                cache_write_q <= 1'b1;
                cache_data_q  <= req_data_i;
                state_q       <= WRITE;
              end else begin
                cache_write_q <= 1'b0;
                cache_data_q  <= '0;
                state_q       <= READ;
              end
            end
          end
        end
        READ: begin
          if (cache_ready_i) begin
            if (store_q) begin
              // second half of read-modify-write: same address, merged word
              cache_write_q <= 1'b1;
              cache_data_q  <= al_merged;
              state_q       <= WRITE;
            end else begin
              cache_valid_q <= 1'b0;
              resp_data_q   <= al_load;
              resp_valid_q  <= 1'b1;
              state_q       <= RESP;
            end
          end
        end
        WRITE: begin
          if (cache_ready_i) begin
            cache_valid_q <= 1'b0;
            cache_write_q <= 1'b0;
            resp_valid_q  <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign resp_valid_o  = resp_valid_q;
  assign resp_data_o   = resp_data_q;
  assign resp_error_o  = resp_error_q;
  assign cache_valid_o = cache_valid_q;
  assign cache_write_o = cache_write_q;
  assign cache_addr_o  = cache_addr_q;
  assign cache_data_o  = cache_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests
// against a word-memory reference model and a latency-checking cache responder.
module tb_load_store_unit;

  logic        clk_i;
  logic        reset_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_store_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        resp_error_o;
  logic        cache_valid_o;
  logic        cache_write_o;
  logic [31:0] cache_addr_o;
  logic [31:0] cache_data_o;
  logic        cache_ready_i;
  logic [31:0] cache_data_i;

  int tests = 0;
  int fails = 0;
  logic [31:0] mem [logic [31:0]];

  load_store_unit #(.ADDR_SIZE(32), .WORD_SIZE(32)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_store_i    (req_store_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .resp_valid_o   (resp_valid_o),
    .resp_data_o    (resp_data_o),
    .resp_error_o   (resp_error_o),
    .cache_valid_o  (cache_valid_o),
    .cache_write_o  (cache_write_o),
    .cache_addr_o   (cache_addr_o),
    .cache_data_o   (cache_data_o),
    .cache_ready_i  (cache_ready_i),
    .cache_data_i   (cache_data_i)
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A3C_96E1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},      req_ready_o,   32'd1);
    check({tag, "_resp_valid"}, resp_valid_o,  32'd0);
    check({tag, "_resp_data"},  resp_data_o,   32'd0);
    check({tag, "_resp_err"},   resp_error_o,  32'd0);
    check({tag, "_c_valid"},    cache_valid_o, 32'd0);
    check({tag, "_c_write"},    cache_write_o, 32'd0);
    check({tag, "_c_addr"},     cache_addr_o,  32'd0);
    check({tag, "_c_data"},     cache_data_o,  32'd0);
  endtask

  // Driver + cache responder + model check for one request. Called at a
  // negedge; returns at the negedge after the response cycle.
  // dly_a/dly_b: ready delay (cycles) for first/second cache phase, <0 = random.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] d,
                        input int dly_a, input int dly_b,
                        output logic [31:0] got_rdata, output logic [31:0] got_wdata);
    logic        err, ph_wr, done;
    logic [31:0] wa, old, szmask, mask, merged, raw, exp_rd, ph_data;
    int          lane, nph, ph, inph, start_k, resp_k, dly;

    lane   = int'(a[1:0]);
    err    = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    wa     = {a[31:2], 2'b00};
    old    = mem_rd(wa);
    szmask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    raw    = (old >> (8 * lane)) & szmask;
    if (!un && sz == 2'd0 && raw[7])  raw = raw | 32'hFFFF_FF00;
    if (!un && sz == 2'd1 && raw[15]) raw = raw | 32'hFFFF_0000;
    exp_rd = (st || err) ? 32'd0 : raw;
    mask   = szmask << (8 * lane);
    merged = (old & ~mask) | ((d & szmask) << (8 * lane));
    nph    = err ? 0 : (st && sz != 2'd2) ? 2 : 1;

    got_rdata = '0;
    got_wdata = '0;
    dly = 0;
    check("req_ready_idle", req_ready_o, 32'd1);
    req_valid_i    = 1'b1;
    req_store_i    = st;
    req_size_i     = sz;
    req_unsigned_i = un;
    req_addr_i     = a;
    req_data_i     = d;
    @(posedge clk_i);
    #1;
    req_valid_i    = 1'b0;
    req_store_i    = 1'($urandom);
    req_size_i     = 2'($urandom);
    req_unsigned_i = 1'($urandom);
    req_addr_i     = $urandom;
    req_data_i     = $urandom;

    ph = 0; inph = 0; start_k = 1; resp_k = 1; done = 1'b0;
    for (int k = 1; k <= 80 && !done; k++) begin
      @(negedge clk_i);
      if (resp_valid_o) begin
        check("resp_latency", k, resp_k);
        check("resp_data", resp_data_o, exp_rd);
        check("resp_error", resp_error_o, err);
        check("phase_count", ph, nph);
        check("cache_idle_at_resp", cache_valid_o, 32'd0);
        got_rdata     = resp_data_o;
        cache_ready_i = 1'b0;
        done          = 1'b1;
      end else if (cache_valid_o && ph >= nph) begin
        check("unexpected_cache_phase", ph, nph - 1);
        cache_ready_i = 1'b0;
        done          = 1'b1;
      end else if (cache_valid_o) begin
        ph_wr   = (ph == 1) || (st && sz == 2'd2);
        ph_data = (ph == 1) ? merged : d;
        if (inph == 0) begin
          check("phase_latency", k, start_k);
          dly = (ph == 0) ? dly_a : dly_b;
          if (dly < 0) dly = $urandom_range(0, 3);
        end
        check("cache_addr", cache_addr_o, wa);
        check("cache_write", cache_write_o, ph_wr);
        if (ph_wr) check("cache_wdata", cache_data_o, ph_data);
        if (inph == dly) begin
          cache_ready_i = 1'b1;
          cache_data_i  = mem_rd(wa);
          if (ph_wr) begin
            mem[wa]   = ph_data;
            got_wdata = cache_data_o;
          end
          ph++;
          inph    = 0;
          start_k = k + 1;
          resp_k  = k + 1;
        end else begin
          cache_ready_i = 1'b0;
          cache_data_i  = $urandom;
          inph++;
        end
      end else begin
        cache_ready_i = 1'b0;
        check("cache_valid_held", cache_valid_o, 32'd1);
      end
    end
    if (!done) check("timeout_no_response", done, 32'd1);
    @(negedge clk_i);
    check("resp_single_pulse", resp_valid_o, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, wd, a, d;
    logic [1:0]  sz;
    logic        st, un;

    reset_ni       = 1'b0;
    req_valid_i    = 1'b0;
    req_store_i    = 1'b0;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    req_addr_i     = '0;
    req_data_i     = '0;
    cache_ready_i  = 1'b0;
    cache_data_i   = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk_i);
    reset_ni = 1'b1;

    // reset while a read phase is outstanding
    req_valid_i = 1'b1; req_store_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h500;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    check("mid_read_valid", cache_valid_o, 32'd1);
    #2 reset_ni = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    mem[32'h0] = 32'h0BAD_F00D;
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1, 0, rd, wd);
    check("post_reset_load", rd, 32'h0BAD_F00D);

    // word load with ready three cycles after valid
    mem[32'h100] = 32'hDEAD_BEEF;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 0, rd, wd);
    check("word_load", rd, 32'hDEAD_BEEF);

    // byte/half loads with sign and zero extension
    mem[32'h100] = 32'h80FF_1234;
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, -1, 0, rd, wd);
    check("byte_load_signed", rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, -1, 0, rd, wd);
    check("byte_load_unsigned", rd, 32'h0000_0080);
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, -1, 0, rd, wd);
    check("half_load_signed", rd, 32'hFFFF_80FF);

    // byte store via read-modify-write
    mem[32'h200] = 32'h1122_3344;
    do_req(1'b1, 2'd0, 1'b0, 32'h201, 32'hAB, 2, 1, rd, wd);
    check("byte_store_merge", wd, 32'h1122_AB44);

    // misaligned accesses never reach the cache
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 0, rd, wd);
    do_req(1'b1, 2'd1, 1'b0, 32'h301, 32'h5555, 0, 0, rd, wd);
    do_req(1'b0, 2'd3, 1'b0, 32'h300, 32'h0, 0, 0, rd, wd);

    // word store with ready tied high, then a back-to-back load
    do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFE_BABE, 0, 0, rd, wd);
    check("word_store_data", wd, 32'hCAFE_BABE);
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0, 0, rd, wd);
    check("back_to_back_load", rd, 32'hCAFE_BABE);

    // randomized mix over a small address window to exercise reuse
    for (int i = 0; i < 300; i++) begin
      st = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom);
      a  = 32'($urandom_range(0, 63));
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a = a & ~32'd3;
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a = a & ~32'd1;
      d  = $urandom;
      do_req(st, sz, un, a, d, -1, -1, rd, wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
